// File: rtl/post_spi_pkg.sv
// Shared types and constants for the Post CPU SPI host and its slave-side speed setting.
package post_spi_pkg;

  // 100 MHz / 2 / 262144 gives roughly 190.7 Hz SCK, the slave's configured rate
  localparam int unsigned HALF_CYC_DEFAULT = 262144;
  localparam int unsigned BIT_CNT_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_TAIL,
    ST_GUARD
  } spi_state_e;

endpackage

// File: rtl/spi_half_timer.sv
// Half-period down-counter: expire pulses for one cycle HALF_CYC cycles after load.
module spi_half_timer
  import post_spi_pkg::*;
#(
  parameter int unsigned HALF_CYC = HALF_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(HALF_CYC);

  logic [CNT_W-1:0] cnt;
  logic             running;

  // load wins over expiry so back-to-back phases chain without a gap cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= CNT_W'(HALF_CYC - 1);
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - CNT_W'(1);
    end
  end

  assign expire = running && (cnt == '0);

endmodule

// File: rtl/post_spi_host.sv
// Byte-wide mode-0 SPI master feeding the Post CPU slave port.
// Optional MISO double-flop synchronizer enabled by defining SPI_MISO_SYNC_EN.
module post_spi_host
  import post_spi_pkg::*;
#(
  parameter int unsigned HALF_CYC = HALF_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       last,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       spi_cs,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  spi_state_e           state, state_next;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           tx_shift, rx_shift;
  logic                 last_q;
  logic                 load, expire, accept, rx_sample, miso_in, finish;

  if (HALF_CYC < 2) begin : g_half_cyc_min
    $error("post_spi_host: HALF_CYC must be at least 2");
  end

`ifdef SPI_MISO_SYNC_EN
  if (HALF_CYC < 4) begin : g_half_cyc_sync
    $error("post_spi_host: HALF_CYC must be at least 4 with SPI_MISO_SYNC_EN");
  end

  logic [1:0] miso_sync;

  always_ff @(posedge clk) begin
    if (rst) miso_sync <= '0;
    else     miso_sync <= {miso_sync[0], spi_miso};
  end

  // two flops of delay are absorbed by sampling at the end of HIGH instead of its start
  assign miso_in   = miso_sync[1];
  assign rx_sample = (state == ST_HIGH) && expire;
`else
  assign miso_in   = spi_miso;
  assign rx_sample = (state_next == ST_HIGH) && (state != ST_HIGH);
`endif

  spi_half_timer #(.HALF_CYC(HALF_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .expire (expire)
  );

  assign accept = (state == ST_IDLE) && start;
  assign finish = (state_next == ST_IDLE) && ((state == ST_TAIL) || (state == ST_GUARD));
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      ST_IDLE:  if (accept) begin state_next = ST_SETUP; load = 1'b1; end
      ST_SETUP: if (expire) begin state_next = ST_HIGH;  load = 1'b1; end
      ST_HIGH:  if (expire) begin
                  state_next = (bit_cnt == '1) ? ST_TAIL : ST_LOW;
                  load       = 1'b1;
                end
      ST_LOW:   if (expire) begin state_next = ST_HIGH;  load = 1'b1; end
      ST_TAIL:  if (expire) begin
                  state_next = last_q ? ST_GUARD : ST_IDLE;
                  load       = last_q;
                end
      ST_GUARD: if (expire) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      last_q   <= 1'b0;
      spi_cs   <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      spi_sck <= (state_next == ST_HIGH);
      done    <= 1'b0;
      if (accept) begin
        tx_shift <= tx_data;
        last_q   <= last;
        bit_cnt  <= '0;
        spi_cs   <= 1'b0;
        spi_mosi <= tx_data[7];
      end
      if (rx_sample) rx_shift <= {rx_shift[6:0], miso_in};
      if ((state == ST_HIGH) && expire) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        // MOSI only moves on the falling SCK edge into LOW
        if (state_next == ST_LOW) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          spi_mosi <= tx_shift[6];
        end
      end
      if ((state == ST_TAIL) && expire && last_q) spi_cs <= 1'b1;
      if (finish) begin
        done    <= 1'b1;
        rx_data <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_post_spi_host.sv
// Self-checking bench for post_spi_host against a behavioural mode-0 SPI slave.
`timescale 1ns/1ps
module tb_post_spi_host;

`ifdef SPI_MISO_SYNC_EN
  localparam int unsigned H = 4;
`else
  localparam int unsigned H = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       last = 1'b0;
  logic       busy, done, spi_cs, spi_sck, spi_mosi;
  logic       spi_miso = 1'b0;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave model state
  int         rises = 0;
  int         nbit = 0;
  int         cs_rises = 0;
  int         done_cnt = 0;
  bit         need_load = 1'b1;
  logic       prev_sck = 1'b0;
  logic       prev_cs = 1'b1;
  logic [7:0] slv_sr = 8'h00;
  logic [7:0] resp_cur = 8'h00;
  logic [7:0] resp_q[$];
  logic [7:0] rx_q[$];

  post_spi_host #(.HALF_CYC(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .last     (last),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .spi_cs   (spi_cs),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // mode-0 slave: capture MOSI on SCK rise, present next MISO bit after SCK fall
  always @(negedge clk) begin
    if (rst) begin
      nbit      = 0;
      need_load = 1'b1;
      spi_miso  = 1'b0;
      resp_q.delete();
      rx_q.delete();
    end else begin
      if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
        slv_sr = {slv_sr[6:0], spi_mosi};
        rises  = rises + 1;
        nbit   = nbit + 1;
        if (nbit == 8) begin
          rx_q.push_back(slv_sr);
          nbit = 0;
        end
      end else if (spi_sck === 1'b0 && prev_sck === 1'b1) begin
        if (nbit == 0) need_load = 1'b1;
        else           spi_miso = resp_cur[7-nbit];
      end
      if (need_load && resp_q.size() != 0) begin
        resp_cur  = resp_q.pop_front();
        need_load = 1'b0;
        spi_miso  = resp_cur[7];
      end
    end
    if (spi_cs === 1'b1 && prev_cs === 1'b0) cs_rises = cs_rises + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    prev_sck = spi_sck;
    prev_cs  = spi_cs;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives START immediately and returns at the negedge of the DONE cycle.
  task automatic xfer(input logic [7:0] d, input logic l, input logic [7:0] resp, input bit poke);
    int          t;
    int          r0;
    bit          seen;
    logic [31:0] got;
    resp_q.push_back(resp);
    start   = 1'b1;
    tx_data = d;
    last    = l;
    t       = cyc;
    r0      = rises;
    @(negedge clk);
    start   = 1'b0;
    tx_data = 8'($urandom);
    last    = 1'($urandom);
    check("busy_cs_after_accept", {30'd0, busy, spi_cs}, 32'b10);
    seen = 1'b0;
    for (int i = 0; i < 30 * H; i++) begin
      if (poke && i == 6) begin start = 1'b1; tx_data = ~d; end
      if (poke && i == 7) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("done_latency", cyc - t, l ? 18 * H + 1 : 17 * H + 1);
    check("rx_data", {24'd0, rx_data}, {24'd0, resp});
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("cs_at_done", {31'd0, spi_cs}, {31'd0, l});
    check("sck_rises", rises - r0, 8);
    got = (rx_q.size() != 0) ? {24'd0, rx_q.pop_front()} : 32'hFFFF_FFFF;
    check("slave_rx", got, {24'd0, d});
  endtask

  initial begin : watchdog
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          r0;
    int          d0;
    int          c0;
    logic [7:0]  d;
    logic [7:0]  r;
    logic        l;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {19'd0, spi_cs, spi_sck, spi_mosi, busy, done, rx_data},
            {19'd0, 5'b10000, 8'h00});
    end

    // single LAST byte
    xfer(8'hA5, 1'b1, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);

    // three-byte frame, each START in the previous DONE cycle
    c0 = cs_rises;
    xfer(8'h01, 1'b0, 8'h11, 1'b0);
    xfer(8'h02, 1'b0, 8'h22, 1'b0);
    check("cs_low_mid_frame", cs_rises - c0, 0);
    xfer(8'h03, 1'b1, 8'h33, 1'b0);
    check("cs_rise_count_frame", cs_rises - c0, 1);
    repeat (3) @(negedge clk);

    // START pulsed mid-transfer is ignored
    d0 = done_cnt;
    xfer(8'h6E, 1'b1, 8'hB1, 1'b1);
    repeat (4) @(negedge clk);
    check("single_done", done_cnt - d0, 1);
    check("no_extra_rises", {30'd0, busy, done}, 32'd0);

    // reset during bit 4
    d0 = done_cnt;
    r0 = rises;
    resp_q.push_back(8'h5A);
    start   = 1'b1;
    tx_data = 8'hC3;
    last    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30 * H; i++) begin
      if (rises - r0 >= 4) break;
      @(negedge clk);
    end
    check("reached_bit4", {31'd0, (rises - r0) >= 4}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_outputs", {19'd0, spi_cs, spi_sck, spi_mosi, busy, done, rx_data},
          {19'd0, 5'b10000, 8'h00});
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20 * H) @(negedge clk);
    check("no_done_after_rst", done_cnt - d0, 0);
    xfer(8'hFF, 1'b1, 8'hE7, 1'b0);
    repeat (2) @(negedge clk);

    // response used to exercise the synchronized sampling path too
    xfer(8'h5F, 1'b1, 8'h96, 1'b0);
    repeat (2) @(negedge clk);

    // randomized transfers
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      r = 8'($urandom);
      l = 1'($urandom_range(0, 1));
      xfer(d, l, r, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
